// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide (shift-add multiply, restoring divide).
// Optional build macro MULDIV_FAST_ZERO_EN lets trivial operands skip CALC.
`ifndef ALU_DATA_WIDTH
`define ALU_DATA_WIDTH 32
`endif

module muldiv_unit #(
  parameter int XLEN  = `ALU_DATA_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic                div_zero_q, div_zero_d;
  logic                div_ovf_q, div_ovf_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     mag_b_q, mag_b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Request decode
  logic            signed_a_in, signed_b_in, sa_in, sb_in;
  logic            div_zero_in, div_ovf_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;

  assign signed_a_in = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign signed_b_in = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign sa_in       = signed_a_in & operand_a[XLEN-1];
  assign sb_in       = signed_b_in & operand_b[XLEN-1];
  assign mag_a_in    = sa_in ? -operand_a : operand_a;
  assign mag_b_in    = sb_in ? -operand_b : operand_b;
  assign div_zero_in = (operand_b == '0);
  assign div_ovf_in  = ((op == OP_DIV) || (op == OP_REM)) && (operand_a == SMIN) && (operand_b == '1);

`ifdef MULDIV_FAST_ZERO_EN
  logic mul_zero_in;
  assign mul_zero_in = !op[2] && ((operand_a == '0) || (operand_b == '0));
`endif

  // One iteration of each algorithm; acc_q low half holds multiplier or dividend bits
  logic [XLEN:0] mul_sum, div_shift, div_diff;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
  assign div_shift = (rem_q << 1) | {{XLEN{1'b0}}, acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mag_b_q};

  // Sign correction applied in FIX
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = sign_a_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

  // NOTE: every signal written below gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div_zero_d = div_zero_q;
    div_ovf_d  = div_ovf_q;
    a_d        = a_q;
    mag_b_d    = mag_b_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    result_d   = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          op_d       = op;
          sign_a_d   = sa_in;
          sign_b_d   = sb_in;
          div_zero_d = div_zero_in;
          div_ovf_d  = div_ovf_in;
          a_d        = operand_a;
          mag_b_d    = mag_b_in;
          acc_d      = {{XLEN{1'b0}}, mag_a_in};
          rem_d      = '0;
          cnt_d      = CNT_W'(XLEN);
          state_d    = S_CALC;
`ifdef MULDIV_FAST_ZERO_EN
          if (div_zero_in || div_ovf_in || mul_zero_in) begin
            cnt_d   = '0;
            state_d = S_FIX;
            if (!op[2]) acc_d = '0;
          end
`endif
        end
      end

      S_CALC: begin
        if (!op_q[2]) begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
          rem_d = div_diff;
          acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = div_shift;
          acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end

      S_FIX: begin
        unique case (op_q)
          OP_MUL:                      result_d = prod_fix[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
          OP_DIV, OP_DIVU:             result_d = div_zero_q ? '1 : (div_ovf_q ? SMIN : quo_fix);
          OP_REM, OP_REMU:             result_d = div_zero_q ? a_q : (div_ovf_q ? '0 : rem_fix);
          default:                     result_d = '0;
        endcase
        state_d = S_DONE;
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (flush) state_d = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      a_q        <= '0;
      mag_b_q    <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div_zero_q <= div_zero_d;
      div_ovf_q  <= div_ovf_d;
      a_q        <= a_d;
      mag_b_q    <= mag_b_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model, scoreboard queue,
// directed RV32M corner cases, backpressure, flush, mid-operation reset and random traffic.
`timescale 1ns/1ps

module tb_muldiv_unit;
  localparam int XLEN = 32;
`ifdef MULDIV_FAST_ZERO_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, out_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] operand_a, operand_b;
  logic            in_ready, out_valid, busy;
  logic [XLEN-1:0] result;

  muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          k;
    int          lat;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   seen  = 1'b0;
  bit   prev_hs = 1'b0;
  bit   prev_stall = 1'b0;
  int   rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int     ia, ib;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (b == 0) || (!f[2] && a == 0) ||
              ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF);
    if (FAST && special) return 1;
    return XLEN + 1;
  endfunction

  // Compare process: latency, result stability and handshake behaviour every cycle
  always @(negedge clk) begin
    if (prev_hs) begin
      check("hs_in_ready_next", {31'b0, in_ready}, 32'd1);
      check("hs_out_valid_drop", {31'b0, out_valid}, 32'd0);
    end
    if (prev_stall && q.size() > 0) check("stall_valid_hold", {31'b0, out_valid}, 32'd1);
    prev_hs    = 1'b0;
    prev_stall = 1'b0;
    if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        if (!seen) begin
          check({q[0].name, "_latency"}, cyc - q[0].k, q[0].lat);
          seen = 1'b1;
        end
        check(q[0].name, result, q[0].res);
        check("done_in_ready", {31'b0, in_ready}, 32'd0);
        check("done_busy", {31'b0, busy}, 32'd1);
        if (out_ready) begin
          void'(q.pop_front());
          seen    = 1'b0;
          prev_hs = 1'b1;
        end else begin
          prev_stall = 1'b1;
        end
      end
    end else if (q.size() > 0 && (cyc - q[0].k) > q[0].lat) begin
      check({q[0].name, "_timeout"}, {31'b0, out_valid}, 32'd1);
      void'(q.pop_front());
      seen = 1'b0;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name);
    bit   done;
    exp_t e;
    done = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = f; operand_a = a; operand_b = b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = exp; e.k = cyc + 1; e.lat = exp_lat(f, a, b); e.name = name;
        q.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) check({name, "_accept"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      check("drain", q.size(), 32'd0);
      q.delete();
      seen = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  d_op  [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
  logic [31:0] d_a   [12] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                              32'd100, 32'd100, 32'd100, 32'd100, 32'h80000000, 32'h80000000};
  logic [31:0] d_b   [12] = '{32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] d_exp [12] = '{32'hFFFFFFCF, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                              32'd14, 32'd2, 32'hFFFFFFFF, 32'd100, 32'h80000000, 32'h0};

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_result", result, 32'd0);

    // Directed corner cases: literal expectations also pin the model
    for (int i = 0; i < 12; i++) begin
      check($sformatf("model_pin_%0d", i), model(d_op[i], d_a[i], d_b[i]), d_exp[i]);
      issue(d_op[i], d_a[i], d_b[i], d_exp[i], $sformatf("directed_%0d", i));
      wait_drain();
    end

    // Backpressure: hold the result for several cycles
    rdy_mode = 2;
    issue(3'd5, 32'd1000, 32'd9, model(3'd5, 32'd1000, 32'd9), "backpressure");
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    rdy_mode = 0;
    wait_drain();

    // Flush a divide in CALC: no response, unit idle next cycle, then a normal MUL
    issue(3'd4, 32'd12345, 32'd17, 32'd0, "flushed_div");
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    q.delete(); seen = 1'b0;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd3, 32'd5, 32'd15, "mul_after_flush");
    wait_drain();

    // Flush together with in_valid in IDLE: nothing accepted
    @(posedge clk); #1;
    in_valid = 1'b1; op = 3'd0; operand_a = 32'd3; operand_b = 32'd4; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_idle_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);

    // Reset mid-operation
    issue(3'd1, 32'h12345678, 32'h9ABCDEF0, 32'd0, "reset_victim");
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    q.delete(); seen = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_result", result, 32'd0);
    issue(3'd6, 32'hFFFFFF9C, 32'd7, model(3'd6, 32'hFFFFFF9C, 32'd7), "after_reset");
    wait_drain();

    // Random traffic with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      issue(f, a, b, model(f, a, b), $sformatf("rnd_op%0d", f));
    end
    wait_drain();
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
